// File: rtl/qed_ctrl_pkg.sv
// Shared types and defaults for the QED duplication controller.
package qed_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ORIG,
    ST_DUP,
    ST_DRAIN
  } qed_state_e;

  localparam int DEPTH_DEFAULT = 16;
  localparam int DRAIN_DEFAULT = 8;

  function automatic int pend_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/qed_dup_ctrl_if.sv
// Boundary bundle of the QED duplication controller: pipeline-side inputs and status outputs.
interface qed_dup_ctrl_if
  import qed_ctrl_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
);
  logic                      ena;
  logic                      dup_req;
  logic                      stall_IF;
  logic                      qic_vld;
  logic                      exec_dup;
  logic [$clog2(DEPTH):0]    pend_cnt;
  logic                      qed_check;
  logic                      qed_err;

  modport master (
    output ena, dup_req, stall_IF, qic_vld,
    input  exec_dup, pend_cnt, qed_check, qed_err
  );

  modport slave (
    input  ena, dup_req, stall_IF, qic_vld,
    output exec_dup, pend_cnt, qed_check, qed_err
  );
endinterface

// File: rtl/qed_pend_counter.sv
// Up/down pending-instruction counter, saturating at DEPTH and at zero.
module qed_pend_counter
  import qed_ctrl_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   inc,
  input  logic                   dec,
  output logic [$clog2(DEPTH):0] cnt,
  output logic                   underflow
);
  localparam int PW = pend_width(DEPTH);
  localparam logic [PW-1:0] CNT_MAX = PW'(DEPTH);

  assign underflow = dec && (cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end
endmodule

// File: rtl/qed_dup_ctrl.sv
// QED round controller: capture originals, issue equal duplicates, drain, then flag a state check.
module qed_dup_ctrl
  import qed_ctrl_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int DRAIN = DRAIN_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ena,
  input  logic                   dup_req,
  input  logic                   stall_IF,
  input  logic                   qic_vld,
  output logic                   exec_dup,
  output logic [$clog2(DEPTH):0] pend_cnt,
  output logic                   qed_check,
  output logic                   qed_err
);
  localparam int PW = pend_width(DEPTH);
  localparam int DW = (DRAIN > 1) ? $clog2(DRAIN) : 1;
  localparam logic [PW-1:0] PEND_MAX   = PW'(DEPTH);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN - 1);

  qed_state_e    state;
  logic [DW-1:0] drain_cnt;
  logic [PW-1:0] cnt_inc;
  logic          cnt_clr;
  logic          cnt_up;
  logic          cnt_dn;
  logic          underflow;
  logic          drain_last;
  logic          dup_go;
  logic          err_evt;

  qed_pend_counter #(.DEPTH(DEPTH)) u_pend (
    .clk       (clk),
    .rst       (rst),
    .clr       (cnt_clr),
    .inc       (cnt_up),
    .dec       (cnt_dn),
    .cnt       (pend_cnt),
    .underflow (underflow)
  );

  always_comb begin
    cnt_inc    = (pend_cnt == PEND_MAX) ? PEND_MAX : pend_cnt + 1'b1;
    drain_last = (drain_cnt == DRAIN_LAST);
    dup_go     = !stall_IF && ((dup_req && (cnt_inc != '0)) || (cnt_inc == PEND_MAX));
    cnt_clr    = !ena || (state == ST_IDLE) || ((state == ST_DRAIN) && drain_last);
    cnt_up     = ena && (state == ST_ORIG) && !stall_IF;
    cnt_dn     = ena && (state == ST_DUP) && !stall_IF;
    // A missing i-cache entry while duplicates are owed breaks the count invariant.
    err_evt    = (state == ST_DUP) && ((!qic_vld && (pend_cnt != '0)) || underflow);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      exec_dup  <= 1'b0;
      drain_cnt <= '0;
      qed_check <= 1'b0;
      qed_err   <= 1'b0;
    end else begin
      qed_check <= 1'b0;
      if (err_evt) begin
        qed_err <= 1'b1;
      end
      if (!ena) begin
        state     <= ST_IDLE;
        exec_dup  <= 1'b0;
        drain_cnt <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            state <= ST_ORIG;
          end
          ST_ORIG: begin
            if (dup_go) begin
              state    <= ST_DUP;
              exec_dup <= 1'b1;
            end
          end
          ST_DUP: begin
            if (!stall_IF && (pend_cnt <= PW'(1))) begin
              state     <= ST_DRAIN;
              exec_dup  <= 1'b0;
              drain_cnt <= '0;
            end
          end
          ST_DRAIN: begin
            if (drain_last) begin
              state     <= ST_ORIG;
              qed_check <= 1'b1;
              drain_cnt <= '0;
            end else begin
              drain_cnt <= drain_cnt + 1'b1;
            end
          end
          default: begin
            state    <= ST_IDLE;
            exec_dup <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_qed_dup_ctrl.sv
// Bench for qed_dup_ctrl: vector table, directed corner sequences and a randomized run vs a round-level model.
module tb_qed_dup_ctrl;
  import qed_ctrl_pkg::*;

  localparam int DEPTH = 16;
  localparam int DRAIN = 8;
  localparam int P_IDLE = 0, P_ORIG = 1, P_DUP = 2, P_DRAIN = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  qed_dup_ctrl_if #(.DEPTH(DEPTH)) bus ();

  qed_dup_ctrl #(.DEPTH(DEPTH), .DRAIN(DRAIN)) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (bus.ena),
    .dup_req   (bus.dup_req),
    .stall_IF  (bus.stall_IF),
    .qic_vld   (bus.qic_vld),
    .exec_dup  (bus.exec_dup),
    .pend_cnt  (bus.pend_cnt),
    .qed_check (bus.qed_check),
    .qed_err   (bus.qed_err)
  );

  int checks = 0;
  int errors = 0;

  // Round-level reference: phase, owed duplicates, remaining drain cycles.
  int m_phase, m_pend, m_drain_left, m_caps, m_last_caps;
  bit m_check, m_err;
  int dut_dups;

  typedef struct {
    bit ena; bit dup; bit stall; bit qic;
    bit exec; int pend; bit chk;
  } vec_t;
  vec_t tv[$];

  function automatic vec_t mk(bit e, bit d, bit s, bit q, bit x, int p, bit c);
    vec_t v;
    v.ena = e; v.dup = d; v.stall = s; v.qic = q; v.exec = x; v.pend = p; v.chk = c;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d @%0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = P_IDLE; m_pend = 0; m_drain_left = 0; m_caps = 0;
    m_check = 0; m_err = 0; dut_dups = 0;
  endtask

  task automatic model_step();
    if (m_phase == P_DUP && ((!bus.qic_vld && m_pend > 0) ||
                             (bus.ena && !bus.stall_IF && m_pend == 0)))
      m_err = 1;
    m_check = 0;
    if (!bus.ena) begin
      m_phase = P_IDLE; m_pend = 0; m_drain_left = 0; m_caps = 0;
    end else begin
      case (m_phase)
        P_IDLE: begin m_phase = P_ORIG; m_pend = 0; m_caps = 0; end
        P_ORIG: if (!bus.stall_IF) begin
          m_caps++;
          if (m_pend < DEPTH) m_pend++;
          if (bus.dup_req || m_pend == DEPTH) m_phase = P_DUP;
        end
        P_DUP: if (!bus.stall_IF) begin
          if (m_pend > 0) m_pend--;
          if (m_pend == 0) begin m_phase = P_DRAIN; m_drain_left = DRAIN; end
        end
        default: begin
          m_drain_left--;
          if (m_drain_left == 0) begin
            m_check = 1; m_phase = P_ORIG; m_pend = 0;
            m_last_caps = m_caps; m_caps = 0;
          end
        end
      endcase
    end
  endtask

  task automatic compare_model(input string tag);
    chk({tag, ".exec_dup"},  bus.exec_dup,  (m_phase == P_DUP));
    chk({tag, ".pend_cnt"},  bus.pend_cnt,  m_pend);
    chk({tag, ".qed_check"}, bus.qed_check, m_check);
    chk({tag, ".qed_err"},   bus.qed_err,   m_err);
  endtask

  task automatic cycle(input string tag);
    bit issued, aborted;
    issued  = bus.exec_dup && !bus.stall_IF && bus.ena && !rst;
    aborted = rst || !bus.ena;
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    #1;
    compare_model(tag);
    if (aborted) dut_dups = 0;
    else dut_dups += int'(issued);
    if (bus.qed_check) begin
      chk({tag, ".round_balance"}, dut_dups, m_last_caps);
      dut_dups = 0;
    end
  endtask

  task automatic drive(input bit e, input bit d, input bit s, input bit q);
    bus.ena = e; bus.dup_req = d; bus.stall_IF = s; bus.qic_vld = q;
  endtask

  task automatic sync_reset();
    rst = 1'b1;
    drive(0, 0, 0, 1);
    cycle("rst");
    rst = 1'b0;
  endtask

  task automatic async_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    compare_model(tag);
    cycle({tag, ".hold"});
    rst = 1'b0;
  endtask

  initial begin
    int cnt_a, cnt_b, peak;
    rst = 1'b1;
    drive(0, 0, 0, 1);
    model_reset();
    #1;
    compare_model("reset_state");
    cycle("reset_hold");
    rst = 1'b0;

    // Basic round: three captures, dup_req on the third, three duplicates, drain, check.
    tv.push_back(mk(1,0,0,1, 0,0,0));
    tv.push_back(mk(1,0,0,1, 0,1,0));
    tv.push_back(mk(1,0,0,1, 0,2,0));
    tv.push_back(mk(1,1,0,1, 1,3,0));
    tv.push_back(mk(1,1,0,1, 1,2,0));
    tv.push_back(mk(1,0,0,1, 1,1,0));
    tv.push_back(mk(1,1,0,1, 0,0,0));
    for (int i = 0; i < DRAIN - 1; i++) tv.push_back(mk(1,i[0],i[1],1, 0,0,0));
    tv.push_back(mk(1,0,1,1, 0,0,1));
    tv.push_back(mk(1,0,1,1, 0,0,0));
    tv.push_back(mk(1,0,0,1, 0,1,0));
    tv.push_back(mk(0,0,0,1, 0,0,0));
    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].ena, tv[i].dup, tv[i].stall, tv[i].qic);
      cycle("tbl");
      chk($sformatf("tbl[%0d].exec_dup", i),  bus.exec_dup,  tv[i].exec);
      chk($sformatf("tbl[%0d].pend_cnt", i),  bus.pend_cnt,  tv[i].pend);
      chk($sformatf("tbl[%0d].qed_check", i), bus.qed_check, tv[i].chk);
      $display("vec %0d ena=%0d dup=%0d stall=%0d -> exec=%0d pend=%0d chk=%0d",
               i, tv[i].ena, tv[i].dup, tv[i].stall, bus.exec_dup, bus.pend_cnt, bus.qed_check);
    end

    // Saturation: no dup_req, counter tops out and duplication starts on its own.
    sync_reset();
    drive(1, 0, 0, 1);
    cnt_a = 0; cnt_b = 0; peak = 0;
    for (int i = 0; i < 2 + 2 * DEPTH + DRAIN; i++) begin
      cycle("sat");
      cnt_a += int'(bus.exec_dup);
      cnt_b += int'(bus.qed_check);
      if (int'(bus.pend_cnt) > peak) peak = int'(bus.pend_cnt);
    end
    chk("sat.peak", peak, DEPTH);
    chk("sat.dup_cycles", cnt_a, DEPTH);
    chk("sat.checks", cnt_b, 1);
    chk("sat.err", bus.qed_err, 0);
    $display("seq saturation peak=%0d dup_cycles=%0d checks=%0d", peak, cnt_a, cnt_b);

    // Stall mid-DUP with five owed duplicates.
    sync_reset();
    drive(1, 0, 0, 1);
    for (int i = 0; i < 5; i++) cycle("stall.setup");
    drive(1, 1, 0, 1);
    cycle("stall.enter");
    drive(1, 0, 1, 1);
    for (int i = 0; i < 2; i++) begin
      cycle("stall.hold");
      chk("stall.pend", bus.pend_cnt, 5);
      chk("stall.exec", bus.exec_dup, 1);
    end
    drive(1, 0, 0, 1);
    cnt_a = 0;
    begin : stall_wait
      for (int i = 0; i < 40; i++) begin
        cnt_a += int'(bus.exec_dup && !bus.stall_IF);
        cycle("stall.run");
        if (bus.qed_check) disable stall_wait;
      end
      chk("stall.timeout", 0, 1);
    end
    chk("stall.decrements", cnt_a, 5);
    $display("seq stall decrements=%0d", cnt_a);

    // i-cache runs dry while duplicates are owed: sticky error.
    sync_reset();
    drive(1, 0, 0, 1);
    cycle("err.setup");
    cycle("err.setup");
    drive(1, 1, 0, 1);
    cycle("err.enter");
    chk("err.pend_before", bus.pend_cnt, 2);
    drive(1, 0, 0, 0);
    cycle("err.hit");
    chk("err.set", bus.qed_err, 1);
    for (int i = 0; i < 20; i++) begin
      drive(i % 7 != 3, 0, 0, 1);
      cycle("err.sticky");
    end
    chk("err.still_set", bus.qed_err, 1);
    async_reset("err.clear");
    chk("err.cleared", bus.qed_err, 0);
    $display("seq sticky error cleared by reset");

    // ena dropped on the final drain cycle: no check pulse.
    drive(1, 0, 0, 1);
    begin : drain_wait
      for (int i = 0; i < 60; i++) begin
        drive(1, (i == 4), 0, 1);
        cycle("abort.run");
        if (m_phase == P_DRAIN && m_drain_left == 1) disable drain_wait;
      end
      chk("abort.timeout", 0, 1);
    end
    drive(0, 0, 0, 1);
    cycle("abort.drop");
    chk("abort.no_check", bus.qed_check, 0);
    chk("abort.pend", bus.pend_cnt, 0);
    drive(1, 0, 0, 1);
    cycle("abort.restart");
    chk("abort.restart_pend", bus.pend_cnt, 0);
    $display("seq ena drop on last drain cycle, check=%0d", bus.qed_check);

    // Asynchronous reset mid-DUP, then no stray check afterwards.
    for (int i = 0; i < 4; i++) cycle("arst.setup");
    drive(1, 1, 0, 1);
    cycle("arst.enter");
    drive(1, 0, 0, 1);
    cycle("arst.dup");
    chk("arst.in_dup", bus.exec_dup, 1);
    async_reset("arst");
    chk("arst.exec", bus.exec_dup, 0);
    cnt_b = 0;
    for (int i = 0; i < DRAIN + 4; i++) begin
      cycle("arst.after");
      cnt_b += int'(bus.qed_check);
    end
    chk("arst.no_check", cnt_b, 0);
    $display("seq async reset mid-DUP");

    // Randomized run against the model.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      drive($urandom_range(0, 49) != 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 39) != 0);
      cycle("rand");
    end
    rst = 1'b0;
    $display("random run done, checks so far %0d", checks);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/qed_dup_ctrl.md
QED_DUP_CTRL -- requirements
Module: qed_dup_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning max original instructions captured per QED round; DEPTH is a power of two, 2..64.
REQ-002 SHALL have parameter DRAIN, default 8, meaning cycles waited after the last duplicate issues before the consistency check.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port ena  input  1  QED mode enable, driven to the instruction mux and i-cache.
REQ-006 SHALL have port dup_req  input  1  request to end the original phase (free input under formal).
REQ-007 SHALL have port stall_IF  input  1  fetch stall; no instruction is consumed in a stalled cycle.
REQ-008 SHALL have port qic_vld  input  1  i-cache vld_out; i-cache holds at least one undelivered instruction.
REQ-009 SHALL have port exec_dup  output  1  selects duplicate instruction issue.
REQ-010 SHALL have port pend_cnt  output  $clog2(DEPTH)+1  originals captured and not yet duplicated.
REQ-011 SHALL have port qed_check  output  1  one-cycle pulse: architectural-state consistency check is valid.
REQ-012 SHALL have port qed_err  output  1  sticky protocol error.

Function
REQ-013 SHALL implement states IDLE, ORIG, DUP, DRAIN; exec_dup=1 only in DUP (registered).
REQ-014 IDLE->ORIG SHALL occur on the first cycle ena=1; pend_cnt=0 on entry.
REQ-015 In ORIG, every cycle with stall_IF=0 SHALL increment pend_cnt by 1, saturating at DEPTH.
REQ-016 ORIG->DUP SHALL occur when stall_IF=0 and either (dup_req=1 and post-increment pend_cnt>=1) or post-increment pend_cnt==DEPTH; the transition is never taken while stall_IF=1.
REQ-017 In DUP, every cycle with stall_IF=0 SHALL decrement pend_cnt by 1; at 1->0, go to DRAIN, with exec_dup=0 from the next cycle.
REQ-018 In DUP, qic_vld=0 while pend_cnt>0 SHALL set qed_err; the FSM still proceeds.
REQ-019 DRAIN SHALL count DRAIN cycles independently of stall_IF; on the last cycle, pulse qed_check for exactly one cycle and return to ORIG with pend_cnt=0.
REQ-020 ena=0 in any state SHALL force IDLE the next cycle, clearing pend_cnt, the drain counter and exec_dup; qed_check is suppressed in that cycle even if the drain ends simultaneously.
REQ-021 dup_req SHALL be ignored outside ORIG and when pend_cnt would be 0.
REQ-022 A DUP->DRAIN transition and ena=0 in the same cycle SHALL resolve to IDLE.
REQ-023 pend_cnt SHALL never exceed DEPTH nor underflow below 0; an attempted underflow sets qed_err.
REQ-024 Exactly as many duplicate issue cycles as original capture cycles SHALL occur per round (count equality is the checked invariant).

Reset
REQ-025 rst=1 SHALL asynchronously force IDLE, exec_dup=0, pend_cnt=0, drain counter=0, qed_check=0 and qed_err=0.
REQ-026 Reset asserted mid-round SHALL discard the round; no qed_check pulse follows reset release.
REQ-027 qed_err SHALL clear only on rst.

Structure
REQ-028 The state enum, DEPTH default and DRAIN default SHALL live in shared package qed_ctrl_pkg.
REQ-029 The up/down saturating pending counter SHALL be sub-module qed_pend_counter; the FSM and drain counter stay in qed_dup_ctrl.
REQ-030 The RTL SHALL be 120-400 lines in total, with no combinational path from stall_IF to exec_dup.

Verification
REQ-031 ena=1, no stalls, dup_req pulsed after 3 captures -> pend_cnt 1,2,3, then exec_dup=1 for 3 cycles, then 8 drain cycles, then a single qed_check pulse.
REQ-032 ena=1, dup_req=0 for 20 cycles, DEPTH=16 -> pend_cnt saturates at 16, auto-enters DUP, 16 dup cycles, no qed_err.
REQ-033 stall_IF=1 for 2 cycles mid-DUP with pend_cnt=5 -> pend_cnt holds at 5, exec_dup stays 1, the round completes with 5 total decrements.
REQ-034 qic_vld=0 in DUP with pend_cnt=2 -> qed_err=1 next cycle and stays 1 until rst.
REQ-035 ena dropped on the final DRAIN cycle -> IDLE, no qed_check pulse, pend_cnt=0.
REQ-036 rst asserted asynchronously mid-DUP -> exec_dup=0 and pend_cnt=0 immediately, no clock edge required.
